// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter that serialises requester jobs onto one shared
// sequential multiplier: clear it, start it, wait for done or a watchdog
// expiry, then hold the response until the consumer accepts it.
module multiplier_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int WIDTH   = 8,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int WDW     = $clog2(TIMEOUT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_multiplicand,
  input  logic [N_REQ*WIDTH-1:0]   req_multiplier,
  output logic                     mul_n_reset,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_multiplicand,
  output logic [WIDTH-1:0]         mul_multiplier,
  input  logic                     mul_ready,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic                     resp_error,
  output logic                     busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WDW-1:0]     wdog_q, wdog_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   mcand_arr [N_REQ];
  logic [WIDTH-1:0]   mplier_arr [N_REQ];
  logic               grant_vld;
  logic [IDW-1:0]     grant_idx;
  int                 cand;

  // Unpack the flat operand buses so the winner can be picked by index.
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign mcand_arr[i]  = req_multiplicand[i*WIDTH +: WIDTH];
    assign mplier_arr[i] = req_multiplier[i*WIDTH +: WIDTH];
  end

  // Round-robin search starting just after the last served requester.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_vld && req_valid[IDW'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
  end

  // Acceptance pulse to the winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!reset && state_q == ST_IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  // Next-state and datapath register update for the job sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    wdog_d       = wdog_q;
    prod_d       = prod_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          id_d     = grant_idx;
          mcand_d  = mcand_arr[grant_idx];
          mplier_d = mplier_arr[grant_idx];
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_START;
      ST_START: begin
        wdog_d  = WDW'(TIMEOUT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_ready) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wdog_q == '0) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          last_grant_d = id_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any job and gives requester 0 first priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
      id_q         <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      wdog_q       <= '0;
      prod_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      wdog_q       <= wdog_d;
      prod_q       <= prod_d;
      err_q        <= err_d;
    end
  end

  // The multiplier stays cleared for the whole reset, not just in CLEAR.
  assign mul_n_reset      = ~reset & (state_q != ST_CLEAR);
  assign mul_start        = (state_q == ST_START);
  assign mul_multiplicand = mcand_q;
  assign mul_multiplier   = mplier_q;
  assign resp_valid       = (state_q == ST_RESP);
  assign resp_id          = id_q;
  assign resp_product     = prod_q;
  assign resp_error       = err_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter with a behavioural sequential
// multiplier (fixed latency) attached to the multiplier-side ports.
module tb_multiplier_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TO  = 8;
  localparam int LAT = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_multiplicand, req_multiplier;
  logic           mul_n_reset, mul_start;
  logic [W-1:0]   mul_multiplicand, mul_multiplier;
  logic           mul_ready;
  logic [2*W-1:0] mul_product;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [1:0]     resp_id;
  logic [2*W-1:0] resp_product;
  logic           resp_error, busy;

  multiplier_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier),
    .mul_n_reset(mul_n_reset), .mul_start(mul_start),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_product(resp_product), .resp_error(resp_error), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural multiplier: done LAT+1 cycles after start, held until cleared.
  logic           m_rdy = 1'b0, m_act = 1'b0, tie0 = 1'b0;
  int             m_cnt = 0;
  logic [2*W-1:0] m_prod = '0;
  always @(posedge clock) begin
    if (!mul_n_reset) begin
      m_rdy <= 1'b0; m_act <= 1'b0; m_cnt <= 0;
    end else if (mul_start) begin
      m_act <= 1'b1; m_cnt <= LAT;
      m_prod <= 16'(mul_multiplicand) * 16'(mul_multiplier);
    end else if (m_act) begin
      if (m_cnt <= 1) begin m_rdy <= 1'b1; m_act <= 1'b0; end
      else m_cnt <= m_cnt - 1;
    end
  end
  assign mul_ready   = m_rdy & ~tie0;
  assign mul_product = m_prod;

  // Per-requester operands and hand-computed products.
  logic [W-1:0]   mc [N] = '{8'd13, 8'd255, 8'd7, 8'd200};
  logic [W-1:0]   mp [N] = '{8'd11, 8'd255, 8'd9, 8'd3};
  logic [2*W-1:0] ep [N] = '{16'd143, 16'd65025, 16'd63, 16'd600};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One complete job from request to handshake, checking every phase.
  task automatic do_job(input logic [N-1:0] vld, input bit drop, input int hold,
                        input int exp_id, input logic [2*W-1:0] exp_p,
                        input logic exp_e, input int exp_waits, input string tag);
    int t;
    int w;
    logic [2*W-1:0] p;
    req_valid  = vld;
    resp_ready = 1'b0;
    #1;
    t = 0;
    while (req_ready == '0 && t < 20) begin @(negedge clock); #1; t++; end
    if (req_ready == '0) begin
      check({tag, " grant_timeout"}, 32'd0, 32'd1);
      req_valid = '0;
      return;
    end
    check({tag, " grant"}, 32'(req_ready), 32'(4'b0001 << exp_id));
    @(negedge clock); #1;
    if (drop) req_valid = '0;
    check({tag, " clear_nrst"}, 32'(mul_n_reset), 32'd0);
    check({tag, " clear_ready"}, 32'(req_ready), 32'd0);
    check({tag, " clear_busy"}, 32'(busy), 32'd1);
    @(negedge clock); #1;
    check({tag, " start"}, 32'(mul_start), 32'd1);
    check({tag, " start_nrst"}, 32'(mul_n_reset), 32'd1);
    check({tag, " op_a"}, 32'(mul_multiplicand), 32'(mc[exp_id]));
    check({tag, " op_b"}, 32'(mul_multiplier), 32'(mp[exp_id]));
    @(negedge clock); #1;
    w = 0;
    while (!resp_valid && w < 40) begin
      w++;
      @(negedge clock); #1;
    end
    check({tag, " wait_cycles"}, 32'(w), 32'(exp_waits));
    if (!resp_valid) begin
      req_valid = '0;
      return;
    end
    check({tag, " resp_id"}, 32'(resp_id), 32'(exp_id));
    check({tag, " resp_product"}, 32'(resp_product), 32'(exp_p));
    check({tag, " resp_error"}, 32'(resp_error), 32'(exp_e));
    p = resp_product;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock); #1;
      check({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold_product"}, 32'(resp_product), 32'(exp_p));
      check({tag, " hold_stable"}, 32'(resp_product), 32'(p));
      check({tag, " hold_ready"}, 32'(req_ready), 32'd0);
      check({tag, " hold_busy"}, 32'(busy), 32'd1);
    end
    resp_ready = 1'b1;
    @(negedge clock); #1;
    resp_ready = 1'b0;
    check({tag, " done_valid"}, 32'(resp_valid), 32'd0);
    check({tag, " done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_multiplicand[i*W +: W] = mc[i];
      req_multiplier[i*W +: W]   = mp[i];
    end
    // Reset state, with requests pending to show they are not acknowledged.
    req_valid = 4'b1111;
    repeat (2) @(negedge clock);
    #1;
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst mul_start", 32'(mul_start), 32'd0);
    check("rst mul_n_reset", 32'(mul_n_reset), 32'd0);
    check("rst resp_id", 32'(resp_id), 32'd0);
    check("rst resp_product", 32'(resp_product), 32'd0);
    check("rst resp_error", 32'(resp_error), 32'd0);
    check("rst op_a", 32'(mul_multiplicand), 32'd0);
    check("rst op_b", 32'(mul_multiplier), 32'd0);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("idle nrst", 32'(mul_n_reset), 32'd1);

    // Single request 13 x 11.
    do_job(4'b0001, 1'b1, 0, 0, 16'd143, 1'b0, 4, "single");
    // Serve requester 3 so the fairness run starts at 0.
    do_job(4'b1000, 1'b1, 0, 3, 16'd600, 1'b0, 4, "prep3");
    for (int j = 0; j < 8; j++)
      do_job(4'b1111, 1'b0, 0, j % 4, ep[j % 4], 1'b0, 4, $sformatf("rr%0d", j));
    // Wrap-around from last_grant = 2.
    do_job(4'b0100, 1'b1, 0, 2, 16'd63, 1'b0, 4, "wrap_prep");
    do_job(4'b0011, 1'b0, 0, 0, 16'd143, 1'b0, 4, "wrap0");
    do_job(4'b0011, 1'b1, 0, 1, 16'd65025, 1'b0, 4, "wrap1");
    // Backpressure on the response with 255 x 255.
    do_job(4'b0010, 1'b0, 5, 1, 16'd65025, 1'b0, 4, "bp");
    // Watchdog expiry.
    tie0 = 1'b1;
    do_job(4'b0001, 1'b1, 0, 0, 16'd0, 1'b1, 8, "timeout");
    tie0 = 1'b0;

    // Reset during WAIT; last_grant is 0 so without reset 1 would win next.
    req_valid = 4'b0110;
    #1;
    check("rw grant", 32'(req_ready), 32'd2);
    @(negedge clock);
    req_valid = '0;
    repeat (3) @(negedge clock);
    #1;
    check("rw in_wait busy", 32'(busy), 32'd1);
    check("rw in_wait start", 32'(mul_start), 32'd0);
    reset = 1'b1;
    #1;
    check("rw nrst", 32'(mul_n_reset), 32'd0);
    check("rw busy", 32'(busy), 32'd0);
    check("rw resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clock); #1;
    check("rw nrst_held", 32'(mul_n_reset), 32'd0);
    check("rw op_a", 32'(mul_multiplicand), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock); #1;
      check("rw no_resp", 32'(resp_valid), 32'd0);
    end
    do_job(4'b0011, 1'b1, 0, 0, 16'd143, 1'b0, 4, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multiplier_arbiter.md
MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of requesters (2..16); WIDTH, default 8, operand width; TIMEOUT, default 64, watchdog cycles (>=2).
REQ-002 Port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  in  1  asynchronous, active-high reset.
REQ-004 Port req_valid  in  N_REQ  per-requester request.
REQ-005 Port req_ready  out  N_REQ  one-hot acceptance pulse.
REQ-006 Port req_multiplicand  in  N_REQ*WIDTH  packed operands; requester i uses slice [i*WIDTH +: WIDTH].
REQ-007 Port req_multiplier  in  N_REQ*WIDTH  packed operands, same slicing.
REQ-008 Port mul_n_reset  out  1  active-low clear to the shared multiplier.
REQ-009 Port mul_start  out  1  start pulse to the multiplier.
REQ-010 Port mul_multiplicand, mul_multiplier  out  WIDTH each  operands to the multiplier.
REQ-011 Port mul_ready  in  1  multiplier done flag; held high until the multiplier is cleared.
REQ-012 Port mul_product  in  2*WIDTH  multiplier result.
REQ-013 Port resp_valid  out  1; resp_ready  in  1; resp_id  out  max(1,$clog2(N_REQ)); resp_product  out  2*WIDTH; resp_error  out  1.
REQ-014 Port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, START, WAIT, RESP.
REQ-016 IDLE: if any req_valid is high, the arbiter SHALL grant in round-robin order, searching from (last_grant+1) mod N_REQ upward with wrap-around.
REQ-017 In the grant cycle, req_ready[winner] SHALL be high combinationally. The winner's operands and index SHALL be registered. The FSM SHALL move to CLEAR.
REQ-018 req_ready SHALL be zero in every state other than IDLE, and zero in IDLE when no req_valid is high.
REQ-019 CLEAR: mul_n_reset SHALL be low for exactly one cycle, then the FSM SHALL go to START.
REQ-020 START: mul_start SHALL be high for exactly one cycle. The watchdog SHALL load TIMEOUT-1. The FSM SHALL go to WAIT.
REQ-021 mul_multiplicand and mul_multiplier SHALL drive the registered operands, stable from START through WAIT.
REQ-022 WAIT: if mul_ready is high, resp_product SHALL capture mul_product, resp_error SHALL be 0, and the FSM SHALL go to RESP.
REQ-023 WAIT: if mul_ready is low and the watchdog is 0, resp_product SHALL be 0, resp_error SHALL be 1, and the FSM SHALL go to RESP.
REQ-024 WAIT: otherwise the watchdog SHALL decrement. mul_ready SHALL be ignored outside WAIT.
REQ-025 RESP: resp_valid SHALL be high. resp_id, resp_product and resp_error SHALL hold stable until the handshake cycle (resp_valid and resp_ready both high).
REQ-026 On the RESP handshake, last_grant SHALL update to resp_id and the FSM SHALL return to IDLE. A new grant SHALL NOT occur in that same cycle.
REQ-027 Latency: grant at cycle T means CLEAR at T+1, START at T+2, first WAIT at T+3. resp_valid SHALL rise the cycle after mul_ready is sampled high in WAIT.
REQ-028 mul_n_reset SHALL be high in all states other than CLEAR. mul_start SHALL be low in all states other than START.
REQ-029 A requester dropping req_valid while not granted SHALL have no effect. Operands SHALL be sampled only in the grant cycle.

Reset
REQ-030 While reset is high: state SHALL be IDLE and last_grant SHALL be N_REQ-1, so requester 0 has first priority.
REQ-031 While reset is high: req_ready, mul_start, resp_valid, resp_error, busy and the watchdog SHALL be 0; resp_product, resp_id and the operand registers SHALL be 0.
REQ-032 mul_n_reset SHALL be low combinationally while reset is high.
REQ-033 Reset asserted mid-operation (any state) SHALL abort the job immediately without a response. The multiplier SHALL be held cleared for the duration of reset.

Verification
REQ-034 Single request: N_REQ=4, WIDTH=8, req_valid=0001 with 13 x 11, resp_ready=1. Required: req_ready=0001 for one cycle, one mul_n_reset low pulse, one mul_start pulse, then resp_valid with resp_id=0, resp_product=143, resp_error=0.
REQ-035 Round-robin fairness: req_valid held at 1111 for eight jobs. Required grant order 0,1,2,3,0,1,2,3.
REQ-036 Wrap-around: last_grant=2 and req_valid=0011. Required: grant to requester 0 next, then requester 1.
REQ-037 Timeout: mul_ready tied 0, TIMEOUT=8. Required: response after exactly 8 WAIT cycles with resp_product=0 and resp_error=1, then return to IDLE.
REQ-038 Backpressure: resp_ready held 0 for 5 cycles in RESP with product 255 x 255. Required: resp_product=65025 stays stable, req_ready stays 0 and busy stays 1 until the handshake.
REQ-039 Reset in WAIT: reset pulsed during WAIT. Required: no resp_valid, mul_n_reset low during reset, and the next request is granted to requester 0.
